usb_spectrum_link: RTL

//  Single-clock successor to the USB command/readout bridge of the MCA design. It pulls 16-bit host

---
 rtl/usb_spectrum_link.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_spectrum_link.sv
// Host command decoder and histogram dump streamer for the ISP1362 USB bridge.
// Define USB_CKSUM_EN to append a 16-bit sum of all dumped words to every dump.
`timescale 1ns/1ps
module usb_spectrum_link #(
  parameter int N_CH = 1024,
  parameter int AW   = 10,
  parameter int DW   = 32
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic [15:0]   rd_data_i,
  input  logic          rd_wait_i,
  output logic          rd_en_o,
  output logic [15:0]   wr_data_o,
  input  logic          wr_wait_i,
  output logic          wr_en_o,
  output logic [AW-1:0] ch_addr_o,
  input  logic [DW-1:0] ch_data_i,
  output logic          cmd_start_o,
  output logic          cmd_pause_o,
  output logic          cmd_clear_o,
  output logic          busy_o,
  output logic [15:0]   last_cmd_o,
  output logic [8:0]    led_o
);

  localparam int WPC = DW / 16;
  localparam int WIW = (WPC > 1) ? $clog2(WPC) : 1;
  localparam logic [WIW-1:0] LASTW  = WIW'(WPC - 1);
  localparam logic [AW-1:0]  LASTCH = AW'(N_CH - 1);

  localparam logic [15:0] CMD_FETCH = 16'hFFFF;
  localparam logic [15:0] CMD_START = 16'hFFEE;
  localparam logic [15:0] CMD_PAUSE = 16'hFFDD;
  localparam logic [15:0] CMD_CLEAR = 16'hFFCC;
  localparam logic [15:0] CMD_ABORT = 16'hFFBB;

  localparam logic [1:0] RIDLE = 2'd0;
  localparam logic [1:0] RCAP  = 2'd1;
  localparam logic [1:0] RDEC  = 2'd2;

  localparam logic [2:0] WIDLE = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRAM  = 3'd2;
  localparam logic [2:0] WSEND = 3'd3;
  localparam logic [2:0] WGAP  = 3'd4;
`ifdef USB_CKSUM_EN
  localparam logic [2:0] WSUM  = 3'd5;
  localparam logic [2:0] WSGAP = 3'd6;
`endif

  logic [1:0]     rState_q, rState_d;
  logic [15:0]    lastCmd_q, lastCmd_d;
  logic [8:0]     led_q, led_d;
  logic           start_q, start_d;
  logic           pause_q, pause_d;
  logic           clear_q, clear_d;
  logic           rdArm_q;
  logic           fetchHit, abortHit;

  logic [2:0]     wState_q, wState_d;
  logic [AW-1:0]  chIdx_q, chIdx_d;
  logic [WIW-1:0] wordIdx_q, wordIdx_d;
  logic [DW-1:0]  shift_q, shift_d;
`ifdef USB_CKSUM_EN
  logic [15:0]    sum_q, sum_d;
`endif

  // Read side: strobe the FIFO, capture the word a cycle later, then decode it.
  always_comb begin
    rState_d  = rState_q;
    lastCmd_d = lastCmd_q;
    led_d     = led_q;
    start_d   = 1'b0;
    pause_d   = 1'b0;
    clear_d   = 1'b0;
    case (rState_q)
      RIDLE: if (rdArm_q && !rd_wait_i) rState_d = RCAP;
      RCAP: begin
        lastCmd_d = rd_data_i;
        rState_d  = RDEC;
      end
      RDEC: begin
        rState_d = RIDLE;
        case (lastCmd_q)
          CMD_FETCH: led_d = 9'h002;
          CMD_START: begin start_d = 1'b1; led_d = 9'h004; end
          CMD_PAUSE: begin pause_d = 1'b1; led_d = 9'h008; end
          CMD_CLEAR: begin clear_d = 1'b1; led_d = 9'h010; end
          CMD_ABORT: led_d = 9'h020;
          default: ;
        endcase
      end
      default: rState_d = RIDLE;
    endcase
  end

  assign fetchHit = (rState_q == RDEC) && (lastCmd_q == CMD_FETCH);
  assign abortHit = (rState_q == RDEC) && (lastCmd_q == CMD_ABORT);

  // Write side: one RAM read per channel, then its words go out low half first with a gap after each.
  always_comb begin
    wState_d  = wState_q;
    chIdx_d   = chIdx_q;
    wordIdx_d = wordIdx_q;
    shift_d   = shift_q;
`ifdef USB_CKSUM_EN
    sum_d     = sum_q;
`endif
    if (abortHit) begin
      wState_d  = WIDLE;
      chIdx_d   = '0;
      wordIdx_d = '0;
    end else begin
      case (wState_q)
        WIDLE: if (fetchHit) begin
          wState_d  = WADDR;
          chIdx_d   = '0;
          wordIdx_d = '0;
`ifdef USB_CKSUM_EN
          sum_d     = '0;
`endif
        end
        WADDR: wState_d = WRAM;
        WRAM: begin
          shift_d  = ch_data_i;
          wState_d = WSEND;
        end
        WSEND: if (!wr_wait_i) begin
          shift_d  = shift_q >> 16;
`ifdef USB_CKSUM_EN
          sum_d    = sum_q + shift_q[15:0];
`endif
          wState_d = WGAP;
        end
        WGAP: begin
          if (wordIdx_q == LASTW) begin
            wordIdx_d = '0;
            if (chIdx_q == LASTCH) begin
`ifdef USB_CKSUM_EN
              wState_d = WSUM;
`else
              wState_d = WIDLE;
`endif
            end else begin
              chIdx_d  = chIdx_q + 1'b1;
              wState_d = WADDR;
            end
          end else begin
            wordIdx_d = wordIdx_q + 1'b1;
            wState_d  = WSEND;
          end
        end
`ifdef USB_CKSUM_EN
        WSUM:  if (!wr_wait_i) wState_d = WSGAP;
        WSGAP: wState_d = WIDLE;
`endif
        default: wState_d = WIDLE;
      endcase
    end
  end

  // rdArm_q keeps rd_en low while reset is held and for the first cycle after release.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rState_q  <= RIDLE;
      lastCmd_q <= '0;
      led_q     <= '0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      clear_q   <= 1'b0;
      rdArm_q   <= 1'b0;
      wState_q  <= WIDLE;
      chIdx_q   <= '0;
      wordIdx_q <= '0;
      shift_q   <= '0;
`ifdef USB_CKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      rState_q  <= rState_d;
      lastCmd_q <= lastCmd_d;
      led_q     <= led_d;
      start_q   <= start_d;
      pause_q   <= pause_d;
      clear_q   <= clear_d;
      rdArm_q   <= 1'b1;
      wState_q  <= wState_d;
      chIdx_q   <= chIdx_d;
      wordIdx_q <= wordIdx_d;
      shift_q   <= shift_d;
`ifdef USB_CKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign rd_en_o     = rdArm_q && (rState_q == RIDLE) && !rd_wait_i;
  assign ch_addr_o   = chIdx_q;
  assign busy_o      = (wState_q != WIDLE);
  assign cmd_start_o = start_q;
  assign cmd_pause_o = pause_q;
  assign cmd_clear_o = clear_q;
  assign last_cmd_o  = lastCmd_q;
  assign led_o       = led_q;
`ifdef USB_CKSUM_EN
  assign wr_en_o     = ((wState_q == WSEND) || (wState_q == WSUM)) && !wr_wait_i;
  assign wr_data_o   = (wState_q == WSUM) ? sum_q : shift_q[15:0];
`else
  assign wr_en_o     = (wState_q == WSEND) && !wr_wait_i;
  assign wr_data_o   = shift_q[15:0];
`endif

endmodule
